// File: rtl/noc_input_port_requester_pkg.sv
// Shared types, constants and the XY routing helper for the input-port requester.
// Port numbering and flit-field offsets used by every router input port.
package noc_input_port_requester_pkg;

  localparam int NOC_VC_CHANNEL  = 2;
  localparam int NOC_FLIT_WIDTH  = 16;
  localparam int NOC_X_W         = 4;
  localparam int NOC_Y_W         = 4;
  localparam int NOC_DEST_X_LSB  = 0;
  localparam int NOC_NUM_PORTS   = 5;
  localparam int NOC_COORD_MAX_W = 16;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_SOUTH = 2;
  localparam int PORT_EAST  = 3;
  localparam int PORT_WEST  = 4;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } noc_flit_type_e;

  typedef enum logic [1:0] {
    VC_IDLE = 2'b00,
    VC_REQ  = 2'b01,
    VC_SEND = 2'b10
  } vc_state_e;

  // Coordinates arrive zero-extended so the comparison stays unsigned at any width.
  function automatic logic [NOC_NUM_PORTS-1:0] noc_xy_route(
    input logic [NOC_COORD_MAX_W-1:0] dest_x,
    input logic [NOC_COORD_MAX_W-1:0] dest_y,
    input logic [NOC_COORD_MAX_W-1:0] cur_x,
    input logic [NOC_COORD_MAX_W-1:0] cur_y
  );
    logic [NOC_NUM_PORTS-1:0] route;
    route = 5'b00000;
    if (dest_x > cur_x) begin
      route[PORT_EAST] = 1'b1;
    end else if (dest_x < cur_x) begin
      route[PORT_WEST] = 1'b1;
    end else if (dest_y > cur_y) begin
      route[PORT_NORTH] = 1'b1;
    end else if (dest_y < cur_y) begin
      route[PORT_SOUTH] = 1'b1;
    end else begin
      route[PORT_LOCAL] = 1'b1;
    end
    return route;
  endfunction

  function automatic logic noc_flit_is_head(input noc_flit_type_e ftype);
    case (ftype)
      FLIT_HEAD, FLIT_SINGLE: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic noc_flit_is_tail(input noc_flit_type_e ftype);
    case (ftype)
      FLIT_TAIL, FLIT_SINGLE: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/noc_input_port_requester_vc_fsm.sv
// One virtual channel's request/grant/stream FSM with its registered output-port choice.
module noc_vc_request_fsm
  import noc_input_port_requester_pkg::*;
#(
  parameter int X_W = NOC_X_W,
  parameter int Y_W = NOC_Y_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [X_W-1:0]           cur_x,
  input  logic [Y_W-1:0]           cur_y,
  input  logic                     valid,
  input  logic [1:0]               flit_type,
  input  logic [X_W-1:0]           dest_x,
  input  logic [Y_W-1:0]           dest_y,
  input  logic [NOC_NUM_PORTS-1:0] grant,
  input  logic                     out_ready,
  output logic                     pop,
  output logic [NOC_NUM_PORTS-1:0] request,
  output logic [NOC_NUM_PORTS-1:0] free,
  output logic                     flit_valid,
  output logic [NOC_NUM_PORTS-1:0] port_sel,
  output logic                     error
);

  vc_state_e                state_q, state_d;
  logic [NOC_NUM_PORTS-1:0] port_q, port_d;
  logic                     head_done_q, head_done_d;
  logic                     error_q, error_d;

  logic                     is_head_s;
  logic                     is_tail_s;
  logic                     grant_s;
  logic                     new_pkt_s;
  logic                     fire_s;
  logic [NOC_NUM_PORTS-1:0] route_s;

  assign is_head_s = noc_flit_is_head(noc_flit_type_e'(flit_type));
  assign is_tail_s = noc_flit_is_tail(noc_flit_type_e'(flit_type));
  assign route_s   = noc_xy_route(NOC_COORD_MAX_W'(dest_x), NOC_COORD_MAX_W'(dest_y),
                                  NOC_COORD_MAX_W'(cur_x),  NOC_COORD_MAX_W'(cur_y));
  assign grant_s   = |(grant & port_q);
  // Once the head has gone out, another head means the previous packet lost its tail.
  assign new_pkt_s = valid & is_head_s & head_done_q;
  assign fire_s    = (state_q == VC_SEND) & valid & grant_s & out_ready & ~new_pkt_s;
  assign error     = error_q;

  // Next-state and per-cycle handshake outputs.
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    head_done_d = head_done_q;
    error_d     = error_q;
    pop         = 1'b0;
    request     = 5'b00000;
    free        = 5'b00000;
    flit_valid  = 1'b0;
    port_sel    = 5'b00000;
    case (state_q)
      VC_IDLE: begin
        if (valid && is_head_s) begin
          port_d      = route_s;
          head_done_d = 1'b0;
          state_d     = VC_REQ;
        end else if (valid) begin
          pop     = 1'b1;
          error_d = 1'b1;
        end else begin
          state_d = VC_IDLE;
        end
      end
      VC_REQ: begin
        request = port_q;
        if (grant_s) begin
          state_d = VC_SEND;
        end else begin
          state_d = VC_REQ;
        end
      end
      VC_SEND: begin
        request  = port_q;
        port_sel = port_q;
        if (new_pkt_s) begin
          free    = port_q;
          error_d = 1'b1;
          port_d  = 5'b00000;
          state_d = VC_IDLE;
        end else begin
          flit_valid = valid & grant_s;
          if (fire_s) begin
            pop         = 1'b1;
            head_done_d = 1'b1;
            if (is_tail_s) begin
              free    = port_q;
              port_d  = 5'b00000;
              state_d = VC_IDLE;
            end else begin
              state_d = VC_SEND;
            end
          end else begin
            state_d = VC_SEND;
          end
        end
      end
      default: begin
        state_d = VC_IDLE;
        port_d  = 5'b00000;
      end
    endcase
  end

  // State, port choice, head-sent marker and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= VC_IDLE;
      port_q      <= 5'b00000;
      head_done_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      head_done_q <= head_done_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: rtl/noc_input_port_requester.sv
// Router input-port requester: one independent request FSM per VC, with the
// port-major request/grant/free buses transposed to and from VC-major form.
module noc_input_port_requester
  import noc_input_port_requester_pkg::*;
#(
  parameter int CHANNELS = NOC_VC_CHANNEL,
  parameter int FLIT_W   = NOC_FLIT_WIDTH,
  parameter int X_W      = NOC_X_W,
  parameter int Y_W      = NOC_Y_W
) (
  input  logic                                    noc_clk,
  input  logic                                    noc_rst_n,
  input  logic [X_W-1:0]                          cur_x,
  input  logic [Y_W-1:0]                          cur_y,
  input  logic [CHANNELS-1:0]                     i_valid,
  input  logic [CHANNELS-1:0][FLIT_W-1:0]         i_flit,
  output logic [CHANNELS-1:0]                     o_pop,
  output logic [NOC_NUM_PORTS-1:0][CHANNELS-1:0]  o_request,
  output logic [NOC_NUM_PORTS-1:0][CHANNELS-1:0]  o_free,
  input  logic [NOC_NUM_PORTS-1:0][CHANNELS-1:0]  i_grant,
  input  logic [CHANNELS-1:0]                     i_out_ready,
  output logic [CHANNELS-1:0]                     o_flit_valid,
  output logic [CHANNELS-1:0][FLIT_W-1:0]         o_flit,
  output logic [CHANNELS-1:0][NOC_NUM_PORTS-1:0]  o_port_sel,
  output logic [CHANNELS-1:0]                     o_error
);

  logic [CHANNELS-1:0][NOC_NUM_PORTS-1:0] grant_s;
  logic [CHANNELS-1:0][NOC_NUM_PORTS-1:0] req_s;
  logic [CHANNELS-1:0][NOC_NUM_PORTS-1:0] free_s;

  assign o_flit = i_flit;

  // Port-major <-> VC-major reshuffle of the arbitration buses.
  always_comb begin
    grant_s   = '0;
    o_request = '0;
    o_free    = '0;
    for (int v = 0; v < CHANNELS; v++) begin
      for (int p = 0; p < NOC_NUM_PORTS; p++) begin
        grant_s[v][p]   = i_grant[p][v];
        o_request[p][v] = req_s[v][p];
        o_free[p][v]    = free_s[v][p];
      end
    end
  end

  for (genvar gv = 0; gv < CHANNELS; gv++) begin : g_vc
    noc_vc_request_fsm #(
      .X_W (X_W),
      .Y_W (Y_W)
    ) u_fsm (
      .clk        (noc_clk),
      .rst_n      (noc_rst_n),
      .cur_x      (cur_x),
      .cur_y      (cur_y),
      .valid      (i_valid[gv]),
      .flit_type  (i_flit[gv][FLIT_W-1 -: 2]),
      .dest_x     (i_flit[gv][NOC_DEST_X_LSB +: X_W]),
      .dest_y     (i_flit[gv][NOC_DEST_X_LSB + X_W +: Y_W]),
      .grant      (grant_s[gv]),
      .out_ready  (i_out_ready[gv]),
      .pop        (o_pop[gv]),
      .request    (req_s[gv]),
      .free       (free_s[gv]),
      .flit_valid (o_flit_valid[gv]),
      .port_sel   (o_port_sel[gv]),
      .error      (o_error[gv])
    );
  end

endmodule

// File: tb/tb_noc_input_port_requester.sv
// Directed and randomized bench for noc_input_port_requester against a packet-level model.
module tb_noc_input_port_requester;

  localparam int CH = 2;
  localparam int FW = 16;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam int CUR_X = 1;
  localparam int CUR_Y = 1;

  logic                    noc_clk = 1'b0;
  logic                    noc_rst_n;
  logic [XW-1:0]           cur_x;
  logic [YW-1:0]           cur_y;
  logic [CH-1:0]           i_valid;
  logic [CH-1:0][FW-1:0]   i_flit;
  logic [CH-1:0]           o_pop;
  logic [4:0][CH-1:0]      o_request;
  logic [4:0][CH-1:0]      o_free;
  logic [4:0][CH-1:0]      i_grant;
  logic [CH-1:0]           i_out_ready;
  logic [CH-1:0]           o_flit_valid;
  logic [CH-1:0][FW-1:0]   o_flit;
  logic [CH-1:0][4:0]      o_port_sel;
  logic [CH-1:0]           o_error;

  always #5 noc_clk = ~noc_clk;

  noc_input_port_requester #(.CHANNELS(CH), .FLIT_W(FW), .X_W(XW), .Y_W(YW)) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .cur_x(cur_x), .cur_y(cur_y),
    .i_valid(i_valid), .i_flit(i_flit), .o_pop(o_pop), .o_request(o_request),
    .o_free(o_free), .i_grant(i_grant), .i_out_ready(i_out_ready),
    .o_flit_valid(o_flit_valid), .o_flit(o_flit), .o_port_sel(o_port_sel), .o_error(o_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // VC buffer contents seen by the DUT, and the packet-level model of each VC.
  logic [FW-1:0] fq [CH][$];
  int   m_port [CH];   // port currently held (request up), -1 when none
  bit   m_live [CH];   // grant seen, packet is streaming
  bit   m_hsent[CH];   // this packet's head already transferred
  bit   m_err  [CH];
  int   n_port [CH];
  bit   n_live [CH], n_hsent[CH], n_err[CH];
  bit   e_pop  [CH], e_fv[CH];
  logic [4:0] e_req[CH], e_free[CH], e_psel[CH];

  int v_prob = 100, g_prob = 100, r_prob = 100, stray_prob = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_route(input int dx, input int dy);
    if (dx > CUR_X) return 3;
    if (dx < CUR_X) return 4;
    if (dy > CUR_Y) return 1;
    if (dy < CUR_Y) return 2;
    return 0;
  endfunction

  function automatic logic [4:0] oh(input int p);
    if (p < 0) return 5'b00000;
    return 5'(1 << p);
  endfunction

  task automatic model_reset();
    for (int v = 0; v < CH; v++) begin
      m_port[v] = -1; m_live[v] = 1'b0; m_hsent[v] = 1'b0; m_err[v] = 1'b0;
    end
  endtask

  task automatic push_raw(input int v, input logic [1:0] ftype);
    logic [FW-1:0] f;
    f = 16'($urandom);
    f[15:14] = ftype;
    fq[v].push_back(f);
  endtask

  task automatic push_pkt(input int v, input int dx, input int dy, input int len, input bit drop_tail);
    logic [FW-1:0] f;
    for (int i = 0; i < len; i++) begin
      f = 16'($urandom);
      if (len == 1)            f[15:14] = 2'b11;
      else if (i == 0)         f[15:14] = 2'b01;
      else if (i == len - 1)   f[15:14] = 2'b10;
      else                     f[15:14] = 2'b00;
      if (i == 0) begin
        f[3:0] = 4'(dx);
        f[7:4] = 4'(dy);
      end
      if (!(drop_tail && len > 1 && i == len - 1)) fq[v].push_back(f);
    end
  endtask

  task automatic drive();
    i_grant = '0;
    for (int v = 0; v < CH; v++) begin
      i_valid[v]     = (fq[v].size() > 0) && ($urandom_range(99) < v_prob);
      i_flit[v]      = (fq[v].size() > 0) ? fq[v][0] : 16'($urandom);
      i_out_ready[v] = ($urandom_range(99) < r_prob);
      if (m_port[v] >= 0 && $urandom_range(99) < g_prob) i_grant[m_port[v]][v] = 1'b1;
      if ($urandom_range(99) < stray_prob) i_grant[$urandom_range(4)][v] = 1'b1;
    end
  endtask

  task automatic eval_check();
    logic [4:0] col_req, col_free;
    bit hd, tl, g, vld, rdy;
    for (int v = 0; v < CH; v++) begin
      vld = i_valid[v]; rdy = i_out_ready[v];
      hd = i_flit[v][14]; tl = i_flit[v][15];
      g  = (m_port[v] >= 0) ? i_grant[m_port[v]][v] : 1'b0;
      e_req[v] = oh(m_port[v]); e_free[v] = 5'b00000; e_psel[v] = 5'b00000;
      e_pop[v] = 1'b0; e_fv[v] = 1'b0;
      n_port[v] = m_port[v]; n_live[v] = m_live[v]; n_hsent[v] = m_hsent[v]; n_err[v] = m_err[v];
      if (m_port[v] < 0) begin
        if (vld && hd) begin
          n_port[v] = ref_route(int'(i_flit[v][3:0]), int'(i_flit[v][7:4]));
          n_live[v] = 1'b0;
        end else if (vld) begin
          e_pop[v] = 1'b1; n_err[v] = 1'b1;
        end
      end else if (!m_live[v]) begin
        if (g) begin n_live[v] = 1'b1; n_hsent[v] = 1'b0; end
      end else begin
        e_psel[v] = oh(m_port[v]);
        if (vld && hd && m_hsent[v]) begin
          e_free[v] = oh(m_port[v]); n_err[v] = 1'b1; n_port[v] = -1; n_live[v] = 1'b0;
        end else begin
          e_fv[v] = vld && g;
          if (e_fv[v] && rdy) begin
            e_pop[v] = 1'b1; n_hsent[v] = 1'b1;
            if (tl) begin e_free[v] = oh(m_port[v]); n_port[v] = -1; n_live[v] = 1'b0; end
          end
        end
      end
      for (int p = 0; p < 5; p++) begin
        col_req[p]  = o_request[p][v];
        col_free[p] = o_free[p][v];
      end
      chk($sformatf("request_vc%0d", v),   col_req,          e_req[v]);
      chk($sformatf("free_vc%0d", v),      col_free,         e_free[v]);
      chk($sformatf("pop_vc%0d", v),       o_pop[v],         e_pop[v]);
      chk($sformatf("flit_valid_vc%0d", v), o_flit_valid[v], e_fv[v]);
      chk($sformatf("port_sel_vc%0d", v),  o_port_sel[v],    e_psel[v]);
      chk($sformatf("error_vc%0d", v),     o_error[v],       m_err[v]);
      chk($sformatf("flit_vc%0d", v),      o_flit[v],        i_flit[v]);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle();
    drive();
    #1;
    eval_check();
    @(posedge noc_clk);
    for (int v = 0; v < CH; v++) begin
      if (e_pop[v] && fq[v].size() > 0) void'(fq[v].pop_front());
      m_port[v] = n_port[v]; m_live[v] = n_live[v]; m_hsent[v] = n_hsent[v]; m_err[v] = n_err[v];
    end
    @(negedge noc_clk);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((fq[0].size() > 0 || fq[1].size() > 0) && k < budget) begin
      cycle();
      k++;
    end
    repeat (3) cycle();
    chk("drain_done", {31'b0, (fq[0].size() == 0 && fq[1].size() == 0)}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_request"},    o_request,    32'd0);
    chk({tag, "_free"},       o_free,       32'd0);
    chk({tag, "_pop"},        o_pop,        32'd0);
    chk({tag, "_error"},      o_error,      32'd0);
    chk({tag, "_flit_valid"}, o_flit_valid, 32'd0);
    chk({tag, "_port_sel"},   o_port_sel,   32'd0);
  endtask

  initial begin
    noc_rst_n = 1'b0;
    cur_x = 4'(CUR_X); cur_y = 4'(CUR_Y);
    i_valid = '0; i_flit = '0; i_grant = '0; i_out_ready = '0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge noc_clk);
    @(negedge noc_clk);
    noc_rst_n = 1'b1;

    // Single flit east, grant withheld for the first request cycle.
    push_pkt(0, 3, 1, 1, 1'b0);
    g_prob = 0;
    repeat (2) cycle();
    g_prob = 100;
    repeat (3) cycle();

    // Four-flit packet south with ready pattern 1,0,1,1,1 once streaming.
    push_pkt(0, 1, 0, 4, 1'b0);
    repeat (2) cycle();
    r_prob = 100; cycle();
    r_prob = 0;   cycle();
    r_prob = 100; repeat (4) cycle();

    // Grant withdrawn for three cycles mid-packet.
    push_pkt(0, 1, 0, 5, 1'b0);
    repeat (3) cycle();
    g_prob = 0;   repeat (3) cycle();
    g_prob = 100; drain(20);

    // Both VCs at once: local on VC0, west on VC1.
    push_pkt(0, 1, 1, 3, 1'b0);
    push_pkt(1, 0, 1, 2, 1'b0);
    drain(20);

    // Stray body in IDLE, then a truncated packet followed by a fresh head.
    push_raw(0, 2'b00);
    cycle();
    push_pkt(0, 2, 2, 3, 1'b1);
    push_pkt(0, 0, 0, 2, 1'b0);
    drain(30);

    // Asynchronous reset in the middle of packets on both VCs.
    push_pkt(0, 3, 3, 6, 1'b0);
    push_pkt(1, 2, 0, 6, 1'b0);
    repeat (5) cycle();
    for (int v = 0; v < CH; v++) fq[v].delete();
    i_valid = '0;
    noc_rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    push_pkt(0, 0, 2, 2, 1'b0);
    push_pkt(1, 1, 3, 1, 1'b0);
    drain(20);

    // Randomized traffic with gaps, back-pressure, stray grants and protocol errors.
    v_prob = 80; g_prob = 70; r_prob = 70; stray_prob = 10;
    for (int c = 0; c < 800; c++) begin
      for (int v = 0; v < CH; v++) begin
        if (fq[v].size() < 3) begin
          if ($urandom_range(99) < 5) push_raw(v, ($urandom_range(1) == 0) ? 2'b00 : 2'b10);
          push_pkt(v, $urandom_range(3), $urandom_range(3), $urandom_range(1, 5),
                   ($urandom_range(99) < 8));
        end
      end
      cycle();
    end
    v_prob = 100; g_prob = 100; r_prob = 100; stray_prob = 0;
    for (int v = 0; v < CH; v++) push_pkt(v, $urandom_range(3), $urandom_range(3), 1, 1'b0);
    drain(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/noc_input_port_requester.md
Name: noc_input_port_requester

Overview:
- Per-input-port initiator for the router's port/VC arbitration protocol; the requester end of the interface driven by the output-port controllers.
- For each input VC: decodes the head flit's destination, computes the output port by XY routing, raises request, waits for grant, streams the packet, and pulses free on the tail flit.
- Sits between an input VC buffer and the five output-port controllers; one instance per router input port.

Parameters:
- CHANNELS, Noc_VC_Channel, number of virtual channels per port
- FLIT_W, Noc_Flit_Width, flit width in bits including the 2-bit type field
- X_W, 4, width of the X coordinate
- Y_W, 4, width of the Y coordinate

Ports:
- noc_clk  in  1  router clock
- noc_rst_n  in  1  asynchronous active-low reset
- cur_x  in  X_W  this router's X coordinate (static)
- cur_y  in  Y_W  this router's Y coordinate (static)
- i_valid  in  CHANNELS  VC buffer head-of-queue flit valid
- i_flit  in  CHANNELS x FLIT_W  VC buffer head-of-queue flit
- o_pop  out  CHANNELS  VC buffer read strobe
- o_request  out  5 x CHANNELS  request[port][vc] to output-port controller
- o_free  out  5 x CHANNELS  one-cycle release[port][vc] on tail transfer
- i_grant  in  5 x CHANNELS  grant[port][vc] from output-port controller
- i_out_ready  in  CHANNELS  switch/downstream can accept a flit on this VC
- o_flit_valid  out  CHANNELS  flit presented to crossbar
- o_flit  out  CHANNELS x FLIT_W  flit to crossbar (i_flit passthrough)
- o_port_sel  out  CHANNELS x 5  one-hot crossbar select
- o_error  out  CHANNELS  sticky protocol-error flag

Behaviour:
- Flit type = i_flit[FLIT_W-1:FLIT_W-2]: 00 body, 01 head, 10 tail, 11 single (head+tail). Head dest_x = bits[X_W-1:0], dest_y = bits[X_W+Y_W-1:X_W].
- Port index: 0 local, 1 north, 2 south, 3 east, 4 west.
- XY route: dest_x>cur_x east; dest_x<cur_x west; else dest_y>cur_y north; dest_y<cur_y south; else local. Comparison is unsigned.
- Reset: all outputs 0, every VC FSM in IDLE, port registers 0, o_error 0.
- Per-VC FSM with states IDLE, REQ, SEND; VCs are fully independent.
- IDLE:
  - i_valid with type head or single: register the route one-hot into port_q; next state REQ. No pop.
  - i_valid with type body or tail: pop the flit (drop it), set o_error[vc] sticky, stay IDLE.
- REQ: o_request[port_q][vc]=1. On i_grant[port_q][vc]=1, go to SEND the next cycle. Minimum head latency is 2 cycles from head valid to first transfer.
- SEND:
  - o_request stays asserted.
  - o_port_sel[vc]=port_q.
  - o_flit_valid = i_valid & i_grant[port_q][vc]; o_flit = i_flit.
  - Transfer occurs when fire = i_valid & i_grant & i_out_ready; o_pop = fire in the same cycle.
- Tail or single fire in SEND: o_free[port_q][vc]=1 for exactly that cycle. Request drops and state returns to IDLE the next cycle.
- Grant drops during SEND (controller grant FIFO full): no fire, state held, request held.
- A head or single flit arriving while in SEND is treated as the next packet's flit: do not fire it, set o_error, and force IDLE after a free pulse. This recovers the channel.
- o_request and o_free are one-hot in the port dimension per VC at all times.
- At most one transfer per VC per cycle; no buffering inside the block. o_flit and o_flit_valid are combinational from registered state plus inputs.
- Asynchronous reset mid-packet: immediately IDLE, request and free deasserted, no free pulse issued.

Decomposition:
- Noc_parameters gains:
  - flit type enum: FLIT_BODY, FLIT_HEAD, FLIT_TAIL, FLIT_SINGLE
  - port index constants: PORT_LOCAL..PORT_WEST
  - X_W/Y_W defaults and field offsets
  - a function noc_xy_route(dest_x, dest_y, cur_x, cur_y) returning a 5-bit one-hot
- One sub-module, noc_vc_request_fsm (one VC's FSM plus port register), generated CHANNELS times in the top level.

Test Plan:
- Basic routing: cur=(1,1); VC0 single flit to (3,1), grant[3][0] given 1 cycle after request -> request[3][0] high 1 cycle before fire; pop, free[3][0] and fire occur in the same cycle; request low the next cycle.
- 4-flit packet, VC0 to (1,0): route is south. Grant held, i_out_ready toggles 1,0,1,1,1 -> exactly 4 pops, free[2][0] only on the tail pop, o_port_sel=00100 throughout SEND.
- Grant withdrawal: grant[2][0] low for 3 cycles mid-packet -> no pops, o_flit_valid=0, request stays high; resumes afterwards.
- Parallel VCs: CHANNELS=2, VC0 to (1,1) local and VC1 to (0,1) west simultaneously -> request[0][0] and request[4][1] concurrently, each freed independently.
- Errors: a body flit in IDLE -> popped, o_error=1 sticky. A head flit in SEND -> free pulse, return to IDLE, then the new head is routed normally.
- Reset: assert noc_rst_n low mid-packet -> all requests, frees, pops and errors are 0 immediately; after release, a fresh head is handled from IDLE.
